// File: rtl/seg_scan_display.sv
// Four-digit multiplexed seven-segment driver for the game display.
// Scans score tens/units and time tens/units and blanks leading zeros.
// The time digits blink while the last five seconds of a game count down.
// All outputs are active-low and registered.
module seg_scan_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_game,
    input  logic [3:0] sec1,
    input  logic [3:0] sec2,
    input  logic [4:0] counter,
    input  logic [3:0] score1,
    input  logic [3:0] score2,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    // packed view of every slow-domain input: {in_game, counter, sec1, sec2, score1, score2}
    logic [21:0] sync_a;
    logic [21:0] sync_b;

    logic       in_game_s;
    logic [4:0] counter_s;
    logic [3:0] sec1_s;
    logic [3:0] sec2_s;
    logic [3:0] score1_s;
    logic [3:0] score2_s;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       idx;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_ph;
    logic             blink_act;

    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] digit;
    logic       lead_blank;

    assign {in_game_s, counter_s, sec1_s, sec2_s, score1_s, score2_s} = sync_b;
    assign tick      = (div_cnt == DIV_MAX);
    assign blink_act = in_game_s && (counter_s != 5'd0) && (counter_s <= 5'd5);

    // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // two-flop synchronizer for everything coming from the 1 Hz timer domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {in_game, counter, sec1, sec2, score1, score2};
            sync_b <= sync_a;
        end
    end

    // prescaler producing one tick per digit slot
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // digit index steps once per slot and wraps naturally from 3 to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // blink phase counter, held cleared whenever the final countdown is not running
    always_ff @(posedge clk) begin
        if (rst || !blink_act) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLK_MAX) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // slot selection, decode, leading-zero and blink blanking for the next output value
    always_comb begin
        an_n       = 4'b1111;
        digit      = 4'd0;
        lead_blank = 1'b0;
        case (idx)
            2'd0: begin
                an_n       = 4'b1110;
                digit      = score1_s;
                lead_blank = (score1_s == 4'd0);
            end
            2'd1: begin
                an_n  = 4'b1101;
                digit = score2_s;
            end
            2'd2: begin
                an_n       = 4'b1011;
                digit      = sec1_s;
                lead_blank = (sec1_s == 4'd0);
            end
            default: begin
                an_n  = 4'b0111;
                digit = sec2_s;
            end
        endcase
        seg_n = lead_blank ? 7'b1111111 : decode(digit);
        // gating with blink_act lets the time digits reappear as soon as blinking stops
        if (idx[1] && blink_ph && blink_act) begin
            an_n  = 4'b1111;
            seg_n = 7'b1111111;
        end
        dp_n = !((idx == 2'd1) && in_game_s);
    end

    // output register giving one clock of latency and glitch-free pins
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_n;
            seg <= seg_n;
            dp  <= dp_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed testbench for seg_scan_display with SCAN_DIV=4, BLINK_DIV=2.
// Slot s is visible on the outputs after edges 4s+1..4s+4 following reset release,
// and synchronized data is valid on the outputs from the third edge onward.
module tb_seg_scan_display;

    logic       clk;
    logic       rst;
    logic       in_game;
    logic [3:0] sec1;
    logic [3:0] sec2;
    logic [4:0] counter;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors_applied;
    int miscompares;

    typedef struct {
        logic       ig;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [4:0] cnt;
        logic [3:0] sc1;
        logic [3:0] sc2;
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    seg_scan_display #(
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_game (in_game),
        .sec1    (sec1),
        .sec2    (sec2),
        .counter (counter),
        .score1  (score1),
        .score2  (score2),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    // free-running 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion first");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input vec_t v);
        in_game = v.ig;
        sec1    = v.s1;
        sec2    = v.s2;
        counter = v.cnt;
        score1  = v.sc1;
        score2  = v.sc2;
    endtask

    // advance n rising edges, then park on the following falling edge
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_an,
                               input logic [6:0] exp_seg, input logic exp_dp);
        vectors_applied++;
        if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
            miscompares++;
            $display("[TB] FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
    endtask

    // two-cycle reset with a check of the reset output state; leaves us before edge E1
    task automatic do_reset();
        rst = 1'b1;
        wait_edges(1);
        checkOutput("reset_state", 4'b1111, 7'b1111111, 1'b1);
        wait_edges(1);
        rst = 1'b0;
    endtask

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        rst     = 1'b1;
        in_game = 1'b0;
        sec1    = 4'd0;
        sec2    = 4'd0;
        counter = 5'd0;
        score1  = 4'd0;
        score2  = 4'd0;

        //          ig    s1     s2     cnt     sc1    sc2   slot an       seg          dp
        vecs[0]  = '{1'b1, 4'd3,  4'd0,  5'd0,  4'd4,  4'd2, 0, 4'b1110, 7'b0011001, 1'b1};
        vecs[1]  = '{1'b1, 4'd3,  4'd0,  5'd0,  4'd4,  4'd2, 1, 4'b1101, 7'b0100100, 1'b0};
        vecs[2]  = '{1'b1, 4'd3,  4'd0,  5'd0,  4'd4,  4'd2, 2, 4'b1011, 7'b0110000, 1'b1};
        vecs[3]  = '{1'b1, 4'd3,  4'd0,  5'd0,  4'd4,  4'd2, 3, 4'b0111, 7'b1000000, 1'b1};
        vecs[4]  = '{1'b1, 4'd0,  4'd7,  5'd20, 4'd0,  4'd8, 0, 4'b1110, 7'b1111111, 1'b1};
        vecs[5]  = '{1'b1, 4'd0,  4'd7,  5'd20, 4'd0,  4'd8, 1, 4'b1101, 7'b0000000, 1'b0};
        vecs[6]  = '{1'b1, 4'd0,  4'd7,  5'd20, 4'd0,  4'd8, 2, 4'b1011, 7'b1111111, 1'b1};
        vecs[7]  = '{1'b1, 4'd0,  4'd7,  5'd20, 4'd0,  4'd8, 3, 4'b0111, 7'b1111000, 1'b1};
        vecs[8]  = '{1'b0, 4'd1,  4'd12, 5'd3,  4'd9,  4'd6, 0, 4'b1110, 7'b0010000, 1'b1};
        vecs[9]  = '{1'b0, 4'd1,  4'd12, 5'd3,  4'd9,  4'd6, 1, 4'b1101, 7'b0000010, 1'b1};
        vecs[10] = '{1'b0, 4'd1,  4'd12, 5'd3,  4'd9,  4'd6, 2, 4'b1011, 7'b1111001, 1'b1};
        vecs[11] = '{1'b0, 4'd1,  4'd12, 5'd3,  4'd9,  4'd6, 3, 4'b0111, 7'b0111111, 1'b1};
        vecs[12] = '{1'b0, 4'd15, 4'd2,  5'd0,  4'd5,  4'd1, 0, 4'b1110, 7'b0010010, 1'b1};
        vecs[13] = '{1'b0, 4'd15, 4'd2,  5'd0,  4'd5,  4'd1, 1, 4'b1101, 7'b1111001, 1'b1};
        vecs[14] = '{1'b0, 4'd15, 4'd2,  5'd0,  4'd5,  4'd1, 2, 4'b1011, 7'b0111111, 1'b1};
        vecs[15] = '{1'b0, 4'd15, 4'd2,  5'd0,  4'd5,  4'd1, 3, 4'b0111, 7'b0100100, 1'b1};
        vecs[16] = '{1'b1, 4'd2,  4'd5,  5'd5,  4'd1,  4'd3, 0, 4'b1110, 7'b1111001, 1'b1};
        vecs[17] = '{1'b1, 4'd2,  4'd5,  5'd5,  4'd1,  4'd3, 1, 4'b1101, 7'b0110000, 1'b0};
        vecs[18] = '{1'b1, 4'd2,  4'd5,  5'd5,  4'd1,  4'd3, 2, 4'b1111, 7'b1111111, 1'b1};
        vecs[19] = '{1'b1, 4'd2,  4'd5,  5'd5,  4'd1,  4'd3, 3, 4'b1111, 7'b1111111, 1'b1};
        vecs[20] = '{1'b1, 4'd2,  4'd5,  5'd0,  4'd1,  4'd3, 2, 4'b1011, 7'b0100100, 1'b1};
        vecs[21] = '{1'b1, 4'd2,  4'd5,  5'd0,  4'd1,  4'd3, 3, 4'b0111, 7'b0010010, 1'b1};
        vecs[22] = '{1'b0, 4'd2,  4'd5,  5'd5,  4'd1,  4'd3, 2, 4'b1011, 7'b0100100, 1'b1};
        vecs[23] = '{1'b0, 4'd2,  4'd5,  5'd5,  4'd1,  4'd3, 3, 4'b0111, 7'b0010010, 1'b1};
        vecs[24] = '{1'b0, 4'd6,  4'd4,  5'd31, 4'd3,  4'd0, 1, 4'b1101, 7'b1000000, 1'b1};
        vecs[25] = '{1'b0, 4'd6,  4'd4,  5'd31, 4'd3,  4'd0, 2, 4'b1011, 7'b0000010, 1'b1};
        vecs[26] = '{1'b0, 4'd6,  4'd4,  5'd31, 4'd3,  4'd0, 3, 4'b0111, 7'b0011001, 1'b1};
        vecs[27] = '{1'b1, 4'd2,  4'd5,  5'd6,  4'd1,  4'd3, 3, 4'b0111, 7'b0010010, 1'b1};
        vecs[28] = '{1'b1, 4'd2,  4'd5,  5'd1,  4'd1,  4'd3, 3, 4'b1111, 7'b1111111, 1'b1};

        @(negedge clk);

        // table: fresh reset per vector, sample on the last edge of the target slot
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            do_reset();
            wait_edges(4 * vecs[i].slot + 4);
            checkOutput($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp);
        end

        // mid-slot data change shows up three edges later within the same slot
        applyStimulus(vecs[0]);
        do_reset();
        wait_edges(1);
        score1 = 4'd7;
        wait_edges(2);
        checkOutput("midslot_old", 4'b1110, 7'b0011001, 1'b1);
        wait_edges(1);
        checkOutput("midslot_new", 4'b1110, 7'b1111000, 1'b1);

        // reset pulse during slot 2 restarts scanning from slot 0
        applyStimulus(vecs[0]);
        do_reset();
        wait_edges(10);
        checkOutput("pre_pulse_slot2", 4'b1011, 7'b0110000, 1'b1);
        rst = 1'b1;
        wait_edges(1);
        checkOutput("pulse_reset", 4'b1111, 7'b1111111, 1'b1);
        rst = 1'b0;
        wait_edges(1);
        checkOutput("resume_slot0_unsynced", 4'b1110, 7'b1111111, 1'b1);
        wait_edges(3);
        checkOutput("resume_slot0_data", 4'b1110, 7'b0011001, 1'b1);
        wait_edges(1);
        checkOutput("resume_slot1", 4'b1101, 7'b0100100, 1'b0);

        // blink begins mid-run; phase is high during the score slots only
        applyStimulus('{1'b1, 4'd2, 4'd5, 5'd9, 4'd1, 4'd3, 0, 4'b0, 7'b0, 1'b0});
        do_reset();
        wait_edges(8);
        counter = 5'd5;
        wait_edges(4);
        checkOutput("onset_slot2_e12", 4'b1011, 7'b0100100, 1'b1);
        wait_edges(8);
        checkOutput("onset_score_e20", 4'b1110, 7'b1111001, 1'b1);
        wait_edges(8);
        checkOutput("onset_slot2_e28", 4'b1011, 7'b0100100, 1'b1);
        wait_edges(4);
        checkOutput("onset_slot3_e32", 4'b0111, 7'b0010010, 1'b1);

        // counter stepping to 0 stops blinking three edges after the change
        applyStimulus(vecs[19]);
        do_reset();
        wait_edges(12);
        checkOutput("stop_blanked_e12", 4'b1111, 7'b1111111, 1'b1);
        counter = 5'd0;
        wait_edges(2);
        checkOutput("stop_still_blank_e14", 4'b1111, 7'b1111111, 1'b1);
        wait_edges(1);
        checkOutput("stop_visible_e15", 4'b0111, 7'b0010010, 1'b1);
        wait_edges(1);
        checkOutput("stop_steady_e16", 4'b0111, 7'b0010010, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, system clocks per digit slot (minimum 2).
REQ-002 Parameter BLINK_DIV, default 250, digit slots per blink phase (minimum 1).
REQ-003 Port clk  in  1  system clock; the block has one clock, all logic on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port in_game  in  1  game-running flag.
REQ-006 Port sec1  in  4  time tens digit from the countdown timer.
REQ-007 Port sec2  in  4  time units digit from the countdown timer.
REQ-008 Port counter  in  5  remaining seconds from the countdown timer.
REQ-009 Port score1  in  4  score tens digit.
REQ-010 Port score2  in  4  score units digit.
REQ-011 Port an  out  4  digit enables, active-low, at most one bit low.
REQ-012 Port seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 Port dp  out  1  decimal point, active-low.

Function
REQ-014 in_game, sec1, sec2, counter, score1 and score2 SHALL each pass through a two-flop synchronizer, because their source runs on the 1 Hz domain; only synchronized values are used.
REQ-015 Prescaler div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; tick is asserted for one clk when div_cnt==SCAN_DIV-1.
REQ-016 Digit index idx (2 bits) SHALL advance on tick, wrapping 3->0; it holds otherwise.
REQ-017 Slot mapping: idx0 -> score1, an=1110; idx1 -> score2, an=1101; idx2 -> sec1, an=1011; idx3 -> sec2, an=0111.
REQ-018 an, seg and dp SHALL be registered and reflect idx and the synchronized data with exactly one clk of latency.
REQ-019 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; values 10..15 SHALL show a dash (0111111).
REQ-020 Leading-zero blanking: in idx0 with score1==0, or in idx2 with sec1==0, seg SHALL be 1111111; an still selects the slot.
REQ-021 dp SHALL be 0 only in idx1 while in_game==1 (score/time separator), otherwise 1.
REQ-022 Blink is active when in_game==1 and 1<=counter<=5.
REQ-023 While blink is active, blink_cnt SHALL count ticks 0..BLINK_DIV-1; on wrap, phase bit blink_ph toggles.
REQ-024 While blink is inactive, blink_cnt=0 and blink_ph=0 on the next clk.
REQ-025 When blink_ph==1, slots idx2 and idx3 SHALL drive an=1111 and seg=1111111; score slots are unaffected.
REQ-026 counter==0 or in_game==0 SHALL show time digits steadily (no blink), with normal decode.
REQ-027 Input changes mid-slot SHALL take effect in the current slot after synchronizer plus output latency (3 clks); there is no per-slot capture.

Reset
REQ-028 With rst high at a clk edge: div_cnt=0, idx=0, blink_cnt=0, blink_ph=0, synchronizer flops=0, an=1111, seg=1111111, dp=1.
REQ-029 Reset SHALL take priority over tick and blink updates on the same edge; reset asserted mid-slot restarts scanning from idx0 on the first clk after release.

Verification (sim with SCAN_DIV=4, BLINK_DIV=2)
REQ-030 Reset release, score=4/2, time=3/0, in_game=1 -> an cycles 1110,1101,1011,0111 every 4 clks; seg 0011001,0100100,0110000,1000000; dp=0 only at an=1101.
REQ-031 score1=0, sec1=0, sec2=7 -> idx0 and idx2 slots show seg=1111111 with an low; idx3 shows 1111000.
REQ-032 in_game=1, counter=5, sec2=5 -> time slots alternate visible/blanked (an=1111) every 8 clks; score slots always visible.
REQ-033 counter steps 5->0 -> blinking stops within 3 clks; blink_ph=0; time slots steady.
REQ-034 sec2=12 -> seg=0111111 in idx3.
REQ-035 rst pulsed one clk while idx=2 -> next outputs an=1111, seg=1111111, dp=1; scan resumes at an=1110.
